clint: RTL

Core-local interruptor: memory-mapped source of the machine timer and software interrupts that the CSR trap logic consumes. Holds a 64-bit free-running `mtime`, a 64-bit `mtimecmp` and a 1-bit `msip`. Drives level-sensitive `o_timer_interrupt` and `o_software_interrupt` into the core. Sits on the data-memory bus beside RAM and is selected by the top-level address decoder.

---
 rtl/clint_pkg.sv | 45 ++++
 rtl/clint.sv | 105 ++++++++++
 2 files changed

// File: rtl/clint_pkg.sv
// Register map and helpers shared by the core-local interruptor.
// Offsets are byte offsets inside the CLINT window; decode uses word bits only.
package clint_pkg;

    localparam logic [15:0] CLINT_MSIP        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_TIME_LO,
        REG_TIME_HI
    } reg_sel_e;

    function automatic reg_sel_e decode_reg(input logic [13:0] word);
        reg_sel_e sel;
        sel = REG_NONE;
        case (word)
            CLINT_MSIP[15:2]:        sel = REG_MSIP;
            CLINT_MTIMECMP_LO[15:2]: sel = REG_CMP_LO;
            CLINT_MTIMECMP_HI[15:2]: sel = REG_CMP_HI;
            CLINT_MTIME_LO[15:2]:    sel = REG_TIME_LO;
            CLINT_MTIME_HI[15:2]:    sel = REG_TIME_HI;
            default:                 sel = REG_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  wsel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (wsel[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/clint.sv
// Core-local interruptor: free-running mtime, mtimecmp and msip behind a
// single-cycle-ack bus port, driving level timer/software interrupts.
module clint
    import clint_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stb,
    input  logic        i_we,
    input  logic [15:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wsel,
    output logic        o_ack,
    output logic [31:0] o_rdata,
    output logic        o_timer_interrupt,
    output logic        o_software_interrupt
);

    localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

    logic [15:0] presc_cnt;
    logic        tick;
    logic [63:0] mtime;
    logic [63:0] mtime_next;
    logic [63:0] mtimecmp;
    logic [63:0] mtimecmp_next;
    logic        msip;
    logic        msip_next;
    logic [31:0] rd_val;
    logic        wr;
    reg_sel_e    sel;
    logic [1:0]  unused_addr;

    assign unused_addr = i_addr[1:0];
    assign sel  = decode_reg(i_addr[15:2]);
    assign wr   = i_stb && i_we;
    assign tick = (presc_cnt == PRESCALE_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 16'd1;
        end
    end

    // A write to either mtime half replaces the increment for the whole
    // 64-bit value that cycle, so no carry leaks into the other half.
    always_comb begin
        mtime_next = mtime;
        if (tick) mtime_next = mtime + 64'd1;
        if (wr && sel == REG_TIME_LO)
            mtime_next = {mtime[63:32], merge_bytes(mtime[31:0], i_wdata, i_wsel)};
        if (wr && sel == REG_TIME_HI)
            mtime_next = {merge_bytes(mtime[63:32], i_wdata, i_wsel), mtime[31:0]};
    end

    always_comb begin
        mtimecmp_next = mtimecmp;
        msip_next     = msip;
        if (wr && sel == REG_CMP_LO)
            mtimecmp_next[31:0] = merge_bytes(mtimecmp[31:0], i_wdata, i_wsel);
        if (wr && sel == REG_CMP_HI)
            mtimecmp_next[63:32] = merge_bytes(mtimecmp[63:32], i_wdata, i_wsel);
        if (wr && sel == REG_MSIP && i_wsel[0])
            msip_next = i_wdata[0];
    end

    always_comb begin
        rd_val = '0;
        case (sel)
            REG_MSIP:    rd_val = {31'd0, msip};
            REG_CMP_LO:  rd_val = mtimecmp[31:0];
            REG_CMP_HI:  rd_val = mtimecmp[63:32];
            REG_TIME_LO: rd_val = mtime[31:0];
            REG_TIME_HI: rd_val = mtime[63:32];
            default:     rd_val = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mtime             <= '0;
            mtimecmp          <= '1;
            msip              <= 1'b0;
            o_ack             <= 1'b0;
            o_rdata           <= '0;
            o_timer_interrupt <= 1'b0;
        end else begin
            mtime             <= mtime_next;
            mtimecmp          <= mtimecmp_next;
            msip              <= msip_next;
            o_ack             <= i_stb;
            o_rdata           <= (i_stb && !i_we) ? rd_val : 32'd0;
            o_timer_interrupt <= (mtime >= mtimecmp);
        end
    end

    assign o_software_interrupt = msip;

endmodule
